// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: owns the PC, issues one imem request at a time and
// holds the returned word in a single-entry slot that feeds decode.
module ifu_fetch #(
  parameter int                   DATAWIDTH = 32,
  parameter logic [DATAWIDTH-1:0] RESET_PC  = DATAWIDTH'(32'h0000_0000),
  parameter logic [DATAWIDTH-1:0] NOP_INSTR = DATAWIDTH'(32'h0000_0013)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 id_ready,
  input  logic                 redirect_valid,
  input  logic [DATAWIDTH-1:0] redirect_pc,
  output logic                 imem_req,
  output logic [DATAWIDTH-1:0] imem_addr,
  input  logic                 imem_rvalid,
  input  logic [DATAWIDTH-1:0] imem_rdata,
  output logic                 if_valid,
  output logic [DATAWIDTH-1:0] instr,
  output logic [DATAWIDTH-1:0] PC_now
);

  typedef enum logic {S_FETCH, S_WAIT} state_t;

  state_t                 state;
  logic [DATAWIDTH-1:0]   pc;
  logic [DATAWIDTH-1:0]   fetch_pc;
  logic                   drop;
  logic                   capture;
  logic [DATAWIDTH-1:0]   redirect_aligned;

  assign redirect_aligned = redirect_pc & ~DATAWIDTH'(3);

  // A request is only issued when the slot is empty or being drained this
  // cycle, so a later capture can never overwrite an unconsumed instruction.
  assign imem_req  = rst_n && (state == S_FETCH) && !redirect_valid &&
                     (!if_valid || id_ready);
  assign imem_addr = pc;
  assign capture   = (state == S_WAIT) && imem_rvalid && !drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      pc       <= RESET_PC;
      fetch_pc <= RESET_PC;
      drop     <= 1'b0;
      if_valid <= 1'b0;
      instr    <= NOP_INSTR;
      PC_now   <= RESET_PC;
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_req) begin
            state    <= S_WAIT;
            fetch_pc <= pc;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            state <= S_FETCH;
            drop  <= 1'b0;
          end else if (redirect_valid) begin
            drop <= 1'b1;
          end
        end
        default: state <= S_FETCH;
      endcase

      // Redirect outranks capture, which outranks plain consumption.
      if (redirect_valid) begin
        pc       <= redirect_aligned;
        if_valid <= 1'b0;
        instr    <= NOP_INSTR;
      end else if (capture) begin
        pc       <= fetch_pc + DATAWIDTH'(4);
        if_valid <= 1'b1;
        instr    <= imem_rdata;
        PC_now   <= fetch_pc;
      end else if (if_valid && id_ready) begin
        if_valid <= 1'b0;
        instr    <= NOP_INSTR;
      end
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed startup/stall/redirect/wrap/reset sequence,
// then randomized traffic, all checked against a transaction-level model.
module tb_ifu_fetch;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] SALT = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] instr;
  logic [31:0] PC_now;

  ifu_fetch dut (
    .clk(clk), .rst_n(rst_n), .id_ready(id_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .instr(instr), .PC_now(PC_now)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Memory: answers each request after mem_lat cycles with addr^SALT^scramble
  int          mem_cnt;
  int          mem_lat;
  logic [31:0] mem_addr;
  logic [31:0] mem_scramble;

  // Model: architectural PC, decode slot, and the one outstanding fetch
  logic [31:0] m_pc, m_instr, m_pcnow, m_fetch;
  logic        m_valid, m_busy, m_discard;
  logic        exp_req;

  logic        s_req, s_valid;
  logic [31:0] s_addr, s_instr, s_pcnow;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic modelReset();
    m_pc = 32'h0; m_instr = NOP; m_pcnow = 32'h0; m_fetch = 32'h0;
    m_valid = 1'b0; m_busy = 1'b0; m_discard = 1'b0;
  endtask

  // One cycle: called just after a rising edge; drives inputs, compares at the
  // falling edge, then advances the model across the next rising edge.
  task automatic applyStimulus(input logic rdy, input logic redir, input logic [31:0] rpc);
    logic keep;
    id_ready = rdy; redirect_valid = redir; redirect_pc = rpc;
    imem_rvalid = 1'b0;
    if (mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_addr ^ SALT ^ mem_scramble;
      end
    end
    @(negedge clk);
    exp_req = !m_busy && !redir && (!m_valid || rdy);
    s_req = imem_req; s_addr = imem_addr; s_valid = if_valid;
    s_instr = instr; s_pcnow = PC_now;
    checkOutput("imem_req", 32'(s_req), 32'(exp_req));
    checkOutput("imem_addr", s_addr, m_pc);
    checkOutput("if_valid", 32'(s_valid), 32'(m_valid));
    checkOutput("instr", s_instr, m_instr);
    checkOutput("PC_now", s_pcnow, m_pcnow);
    if (imem_req && mem_cnt == 0) begin
      mem_cnt  = mem_lat;
      mem_addr = imem_addr;
    end
    @(posedge clk);
    keep = 1'b0;
    if (exp_req) begin
      m_busy  = 1'b1;
      m_fetch = m_pc;
    end else if (m_busy && imem_rvalid) begin
      m_busy    = 1'b0;
      keep      = !m_discard && !redir;
      m_discard = 1'b0;
    end else if (m_busy && redir) begin
      m_discard = 1'b1;
    end
    if (redir) begin
      m_pc = {rpc[31:2], 2'b00}; m_valid = 1'b0; m_instr = NOP;
    end else if (keep) begin
      m_valid = 1'b1; m_instr = imem_rdata; m_pcnow = m_fetch; m_pc = m_fetch + 32'd4;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0; m_instr = NOP;
    end
    #1;
  endtask

  initial begin
    rst_n = 1'b0; id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_rvalid = 1'b0; imem_rdata = '0;
    mem_cnt = 0; mem_lat = 1; mem_addr = '0; mem_scramble = '0;
    modelReset();
    #12;
    checkOutput("rst_if_valid", 32'(if_valid), 32'd0);
    checkOutput("rst_instr", instr, NOP);
    checkOutput("rst_PC_now", PC_now, 32'h0);
    checkOutput("rst_imem_req", 32'(imem_req), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Startup with 1-cycle memory
    applyStimulus(1, 0, 0);
    checkOutput("lit_first_req", 32'(s_req), 32'd1);
    checkOutput("lit_first_addr", s_addr, 32'h0);
    applyStimulus(1, 0, 0);
    checkOutput("lit_wait_noreq", 32'(s_req), 32'd0);
    applyStimulus(1, 0, 0);
    checkOutput("lit_first_valid", 32'(s_valid), 32'd1);
    checkOutput("lit_first_instr", s_instr, 32'hA5A5_0000);
    checkOutput("lit_first_pcnow", s_pcnow, 32'h0);
    checkOutput("lit_second_addr", s_addr, 32'h4);
    applyStimulus(1, 0, 0);

    // Back-pressure with a full slot
    repeat (5) applyStimulus(0, 0, 0);
    checkOutput("lit_stall_req", 32'(s_req), 32'd0);
    checkOutput("lit_stall_instr", s_instr, 32'hA5A5_0004);
    checkOutput("lit_stall_pcnow", s_pcnow, 32'h4);
    mem_lat = 2;
    applyStimulus(1, 0, 0);
    checkOutput("lit_release_req", 32'(s_req), 32'd1);
    checkOutput("lit_release_addr", s_addr, 32'h8);

    // Redirect while waiting on 0x8
    applyStimulus(1, 1, 32'h100);
    mem_lat = 1;
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 0);
    checkOutput("lit_redir_valid", 32'(s_valid), 32'd0);
    checkOutput("lit_redir_addr", s_addr, 32'h100);
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 0);
    checkOutput("lit_redir_pcnow", s_pcnow, 32'h100);
    checkOutput("lit_redir_instr", s_instr, 32'hA5A5_0100);

    // Redirect coincident with rvalid, unaligned target
    applyStimulus(1, 1, 32'h203);
    applyStimulus(1, 0, 0);
    checkOutput("lit_unalign_addr", s_addr, 32'h200);
    checkOutput("lit_unalign_valid", 32'(s_valid), 32'd0);

    // Wrap at the top of the address space
    applyStimulus(1, 1, 32'hFFFF_FFFC);
    applyStimulus(1, 0, 0);
    checkOutput("lit_top_addr", s_addr, 32'hFFFF_FFFC);
    applyStimulus(1, 0, 0);
    mem_lat = 3;
    applyStimulus(1, 0, 0);
    checkOutput("lit_top_pcnow", s_pcnow, 32'hFFFF_FFFC);
    checkOutput("lit_top_instr", s_instr, 32'h5A5A_FFFC);
    checkOutput("lit_wrap_addr", s_addr, 32'h0);

    // Asynchronous reset while a fetch is outstanding
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_if_valid", 32'(if_valid), 32'd0);
    checkOutput("async_instr", instr, NOP);
    checkOutput("async_PC_now", PC_now, 32'h0);
    checkOutput("async_imem_req", 32'(imem_req), 32'd0);
    mem_cnt = 0; imem_rvalid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    modelReset();
    mem_lat = 1;
    applyStimulus(1, 0, 0);
    checkOutput("lit_post_rst_req", 32'(s_req), 32'd1);
    checkOutput("lit_post_rst_addr", s_addr, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic        rdy, redir;
      logic [31:0] rpc;
      mem_lat      = $urandom_range(1, 3);
      mem_scramble = $urandom;
      rdy          = ($urandom_range(0, 3) != 0);
      redir        = ($urandom_range(0, 9) == 0);
      rpc          = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                 : 32'($urandom);
      applyStimulus(rdy, redir, rpc);
    end

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
